// File: rtl/coeff_ram_controller.sv
// Coefficient RAM sequencer: streams all N coefficients through port B to the MAC with
// tap/phase tags, and serialises host writes onto port A while no sequence is in flight.
module coeff_ram_controller #(
    parameter int unsigned addrWidth    = 12,
    parameter int unsigned dataWidth    = 18,
    parameter int unsigned tapsPerPhase = 4,
    parameter int unsigned numPhases    = 4
) (
    input  logic                   Clk_i,
    input  logic                   Rstn_i,
    input  logic                   Start_i,
    output logic                   Busy_o,
    output logic                   Overrun_o,
    input  logic                   HostWrReq_i,
    input  logic [addrWidth-1:0]   HostAddr_i,
    input  logic [dataWidth-1:0]   HostData_i,
    output logic                   HostWrAck_o,
    output logic [addrWidth-1:0]   RamAddra_o,
    output logic                   RamWea_o,
    output logic [dataWidth-1:0]   RamDina_o,
    output logic [addrWidth-1:0]   RamAddrb_o,
    input  logic [dataWidth-1:0]   RamDoutb_i,
    output logic                   CoefValid_o,
    output logic [dataWidth-1:0]   Coef_o,
    output logic [(numPhases > 1 ? $clog2(numPhases) : 1)-1:0] PhaseIdx_o,
    output logic [$clog2(tapsPerPhase)-1:0]                    TapIdx_o,
    output logic                   FirstTap_o,
    output logic                   LastTap_o
);

    localparam int unsigned phase_w = (numPhases > 1) ? $clog2(numPhases) : 1;
    localparam int unsigned tap_w   = $clog2(tapsPerPhase);

    localparam logic [tap_w-1:0]   last_tap   = tap_w'(tapsPerPhase - 1);
    localparam logic [phase_w-1:0] last_phase = phase_w'(numPhases - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN1,
        ST_DRAIN2,
        ST_WRITE
    } state_t;

    state_t               state_q, state_d;
    logic [tap_w-1:0]     tap_q, tap_d;
    logic [phase_w-1:0]   phase_q, phase_d;
    logic [addrWidth-1:0] addrb_q, addrb_d;
    logic [addrWidth-1:0] addra_q, addra_d;
    logic [dataWidth-1:0] dina_q, dina_d;
    logic                 wea_q, wea_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [tap_w-1:0]     s1_tap_q, s1_tap_d;
    logic [phase_w-1:0]   s1_phase_q, s1_phase_d;
    logic                 coef_valid_q, coef_valid_d;
    logic [dataWidth-1:0] coef_q, coef_d;
    logic [tap_w-1:0]     tap_idx_q, tap_idx_d;
    logic [phase_w-1:0]   phase_idx_q, phase_idx_d;
    logic                 first_tap_q, first_tap_d;
    logic                 last_tap_q, last_tap_d;

    // Next-state, address walk, write issue and tag pipeline
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        phase_d      = phase_q;
        addrb_d      = addrb_q;
        addra_d      = addra_q;
        dina_d       = dina_q;
        wea_d        = 1'b0;
        ack_d        = 1'b0;
        overrun_d    = overrun_q | (Start_i && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    state_d = ST_RUN;
                    tap_d   = '0;
                    phase_d = '0;
                    addrb_d = '0;
                end else if (HostWrReq_i) begin
                    state_d = ST_WRITE;
                    wea_d   = 1'b1;
                    ack_d   = 1'b1;
                    addra_d = HostAddr_i;
                    dina_d  = HostData_i;
                end
            end
            ST_RUN: begin
                if ((tap_q == last_tap) && (phase_q == last_phase)) begin
                    state_d = ST_DRAIN1;
                end else begin
                    addrb_d = addrb_q + addrWidth'(1);
                    if (tap_q == last_tap) begin
                        tap_d   = '0;
                        phase_d = phase_q + phase_w'(1);
                    end else begin
                        tap_d   = tap_q + tap_w'(1);
                    end
                end
            end
            ST_DRAIN1: state_d = ST_DRAIN2;
            ST_DRAIN2: state_d = ST_IDLE;
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d       = (state_d != ST_IDLE);

        // Stage 1 carries the tags of the address currently on port B
        s1_valid_d   = (state_q == ST_RUN);
        s1_tap_d     = tap_q;
        s1_phase_d   = phase_q;

        // Stage 2 lines up the tags with the RAM read data
        coef_valid_d = s1_valid_q;
        coef_d       = s1_valid_q ? RamDoutb_i : '0;
        tap_idx_d    = s1_valid_q ? s1_tap_q : '0;
        phase_idx_d  = s1_valid_q ? s1_phase_q : '0;
        first_tap_d  = s1_valid_q && (s1_tap_q == '0);
        last_tap_d   = s1_valid_q && (s1_tap_q == last_tap);
    end

    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            phase_q      <= '0;
            addrb_q      <= '0;
            addra_q      <= '0;
            dina_q       <= '0;
            wea_q        <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_tap_q     <= '0;
            s1_phase_q   <= '0;
            coef_valid_q <= 1'b0;
            coef_q       <= '0;
            tap_idx_q    <= '0;
            phase_idx_q  <= '0;
            first_tap_q  <= 1'b0;
            last_tap_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            phase_q      <= phase_d;
            addrb_q      <= addrb_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            wea_q        <= wea_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            s1_valid_q   <= s1_valid_d;
            s1_tap_q     <= s1_tap_d;
            s1_phase_q   <= s1_phase_d;
            coef_valid_q <= coef_valid_d;
            coef_q       <= coef_d;
            tap_idx_q    <= tap_idx_d;
            phase_idx_q  <= phase_idx_d;
            first_tap_q  <= first_tap_d;
            last_tap_q   <= last_tap_d;
        end
    end

    assign Busy_o      = busy_q;
    assign Overrun_o   = overrun_q;
    assign HostWrAck_o = ack_q;
    assign RamAddra_o  = addra_q;
    assign RamWea_o    = wea_q;
    assign RamDina_o   = dina_q;
    assign RamAddrb_o  = addrb_q;
    assign CoefValid_o = coef_valid_q;
    assign Coef_o      = coef_q;
    assign PhaseIdx_o  = phase_idx_q;
    assign TapIdx_o    = tap_idx_q;
    assign FirstTap_o  = first_tap_q;
    assign LastTap_o   = last_tap_q;

endmodule

// File: tb/tb_coeff_ram_controller.sv
// Bench for coeff_ram_controller: bench-side dual-port RAM, timeline-based reference model,
// directed scenarios with literal expectations, then randomized start/write/reset traffic.
module tb_coeff_ram_controller;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 18;
    localparam int unsigned T  = 4;
    localparam int unsigned P  = 4;
    localparam int          N  = T * P;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          req = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [DW-1:0] hdata = '0;
    logic          busy, overrun, ack, wea, coefv, first_t, last_t;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, doutb, coef;
    logic [1:0]    phase_idx, tap_idx;

    always #5 clk = ~clk;

    coeff_ram_controller #(
        .addrWidth(AW), .dataWidth(DW), .tapsPerPhase(T), .numPhases(P)
    ) dut (
        .Clk_i(clk), .Rstn_i(rstn), .Start_i(start), .Busy_o(busy), .Overrun_o(overrun),
        .HostWrReq_i(req), .HostAddr_i(haddr), .HostData_i(hdata), .HostWrAck_o(ack),
        .RamAddra_o(addra), .RamWea_o(wea), .RamDina_o(dina), .RamAddrb_o(addrb),
        .RamDoutb_i(doutb), .CoefValid_o(coefv), .Coef_o(coef), .PhaseIdx_o(phase_idx),
        .TapIdx_o(tap_idx), .FirstTap_o(first_t), .LastTap_o(last_t)
    );

    // Dual-port RAM with registered port B read
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (wea) ram[addra] <= dina;
        doutb <= ram[addrb];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: edge e starts cycle e+1; the DUT is free when e >= free_at.
    int            e = 0;
    int            free_at = 0;
    int            seq_s = 0;
    bit            seq_on = 1'b0;
    int            wr_t = -10;
    logic [AW-1:0] wr_a = '0;
    logic [DW-1:0] wr_d = '0;
    int            k, ci;
    bit            x_rst, x_busy, x_ovr, x_wea, x_aval, x_cval;
    logic [AW-1:0] x_addra = '0;
    logic [DW-1:0] x_coef;
    int            x_ph, x_tp;
    logic [DW-1:0] got[$];
    int            ack_cnt = 0;
    int            valid_cnt = 0;

    always @(posedge clk) begin
        if (e == wr_t + 1) ref_mem[wr_a] = wr_d;
        x_rst = !rstn;
        if (!rstn) begin
            seq_on  = 1'b0;
            free_at = 0;
            wr_t    = -10;
            x_ovr   = 1'b0;
            x_addra = '0;
        end else if (e >= free_at) begin
            if (start) begin
                seq_on  = 1'b1;
                seq_s   = e;
                free_at = e + N + 3;
            end else if (req) begin
                wr_t    = e;
                wr_a    = haddr;
                wr_d    = hdata;
                x_addra = haddr;
                free_at = e + 2;
            end
        end else if (start) begin
            x_ovr = 1'b1;
        end
        k      = e + 1 - seq_s;
        x_busy = (e + 1 < free_at);
        x_wea  = (wr_t == e);
        x_aval = seq_on && k >= 1 && k <= N;
        x_cval = seq_on && k >= 3 && k <= N + 2;
        ci     = k - 3;
        x_ph   = 0;
        x_tp   = 0;
        x_coef = '0;
        if (x_cval) begin
            x_coef = ref_mem[ci];
            x_ph   = ci / T;
            x_tp   = ci % T;
        end
        e++;
        #1;
        chk("busy", 32'(busy), 32'(x_busy));
        chk("overrun", 32'(overrun), 32'(x_ovr));
        chk("host_ack", 32'(ack), 32'(x_wea));
        chk("ram_wea", 32'(wea), 32'(x_wea));
        chk("ram_addra", 32'(addra), 32'(x_addra));
        chk("coef_valid", 32'(coefv), 32'(x_cval));
        chk("first_tap", 32'(first_t), 32'(x_cval && x_tp == 0));
        chk("last_tap", 32'(last_t), 32'(x_cval && x_tp == T - 1));
        if (x_wea) chk("ram_dina", 32'(dina), 32'(wr_d));
        if (x_aval) chk("ram_addrb", 32'(addrb), 32'(k - 1));
        if (x_cval) begin
            chk("coef", 32'(coef), 32'(x_coef));
            chk("phase_idx", 32'(phase_idx), 32'(x_ph));
            chk("tap_idx", 32'(tap_idx), 32'(x_tp));
        end
        if (x_rst) begin
            chk("rst_addrb", 32'(addrb), 32'd0);
            chk("rst_coef", 32'(coef), 32'd0);
            chk("rst_dina", 32'(dina), 32'd0);
            chk("rst_tags", {28'd0, phase_idx, tap_idx}, 32'd0);
        end
        if (coefv) begin
            got.push_back(coef);
            valid_cnt++;
        end
        if (ack) ack_cnt++;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise a write request and hold it until acked; returns cycles waited (-1 on timeout)
    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_start,
                              output int waited);
        req   = 1'b1;
        haddr = a;
        hdata = d;
        start = with_start;
        waited = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (ack) begin
                waited = i;
                break;
            end
        end
        req = 1'b0;
        if (waited < 0) chk("host_ack_timeout", 32'd0, 32'd1);
    endtask

    int n, a0, v0;
    logic [DW-1:0] v;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[0] = 18'h3e6c9; ram[1] = 18'h3c349; ram[2] = 18'h3cfde;
        ram[3] = 18'h3f440; ram[4] = 18'h05e4b; ram[15] = 18'h3e6c9;
        for (int i = 0; i < N; i++) ref_mem[i] = ram[i];

        // Reset with random inputs
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); req = 1'($urandom);
            haddr = AW'($urandom); hdata = DW'($urandom);
            @(negedge clk);
        end
        start = 1'b0; req = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(coefv), 32'd0);
        rstn = 1'b1;
        cycles(2);

        // Full sequence at initial contents
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(N + 4);
        chk("seq_count", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            chk("seq_coef0", 32'(got[0]), 32'h3e6c9);
            chk("seq_coef1", 32'(got[1]), 32'h3c349);
            chk("seq_coef2", 32'(got[2]), 32'h3cfde);
            chk("seq_coef3", 32'(got[3]), 32'h3f440);
            chk("seq_coef4", 32'(got[4]), 32'h05e4b);
            chk("seq_coef15", 32'(got[15]), 32'h3e6c9);
        end

        // Host write then sequence
        a0 = ack_cnt;
        host_write(AW'(5), 18'h12345, 1'b0, n);
        chk("write_latency", 32'(n), 32'd1);
        cycles(2);
        chk("write_ack_once", 32'(ack_cnt - a0), 32'd1);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(N + 4);
        chk("seq2_count", 32'(got.size()), 32'd16);
        if (got.size() == 16) chk("seq2_coef5", 32'(got[5]), 32'h12345);

        // Start and write in the same idle cycle: write waits for the sequence
        host_write(AW'(40), 18'h0abcd, 1'b1, n);
        chk("write_after_seq", 32'(n), 32'(N + 4));
        cycles(3);

        // Start during a run is ignored and flagged
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(N + 4);
        chk("overrun_count", 32'(got.size()), 32'd16);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-run aborts the sequence
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(7);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("abort_valid", 32'(coefv), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        v0 = valid_cnt;
        cycles(20);
        chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles(N + 4);
        chk("after_abort_count", 32'(got.size()), 32'd16);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 11) == 0);
            rstn  = ($urandom_range(0, 299) != 0);
            if (req && ack) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 5) == 0) begin
                req   = 1'b1;
                haddr = AW'($urandom_range(0, 31));
                hdata = DW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        req   = 1'b0;
        rstn  = 1'b1;
        cycles(N + 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
